hpf_out_buffer: RTL and testbench
=================================

# hpf_out_buffer

Downstream stage of the 13-tap FIR high-pass filter. Consumes the filter's 14-bit signed output stream (one sample per `Clk`), discards the pipeline-fill transient after reset, and optionally decimates. Buffers the surviving samples in a small FIFO and presents them to the consumer over a valid/ready handshake. Overruns are flagged, never stalled, because the filter cannot be back-pressured.

## Interface
- `WARMUP`, default 13: number of valid input samples discarded after reset. Covers the 12 tap delay registers plus the output register.
- `DECIM`, default 1: keep every DECIM-th post-warm-up sample. Legal range 1..16.
- `DEPTH`, default 16: FIFO entries. Must be a power of 2, ≥2.
- `Clk` input 1: single clock, rising edge.
- `Rst` input 1: asynchronous, active-high reset.
- `Din` input 14 signed: filter output (`Out`), registered upstream.
- `Din_valid` input 1: sample qualifier. Tied high when driven directly by the filter.
- `Dout` output 14 signed: FIFO head. Forced to 0 when empty.
- `Dout_valid` output 1: FIFO non-empty.
- `Dout_ready` input 1: consumer accepts the head this cycle.
- `Level` output $clog2(DEPTH)+1: current occupancy.
- `Ovf` output 1: sticky; set when a kept sample was dropped because the FIFO was full.
- `Ovf_clr` input 1: synchronous clear of `Ovf` and `Drop_cnt`.
- `Drop_cnt` output 8: saturating count of dropped samples. See Configuration.

## Operation
- State machine has 2 states.
  - WARMUP (reset state): counts valid input samples and discards them all. Moves to RUN on the cycle the WARMUP-th valid sample is discarded. If WARMUP=0, the block starts in RUN.
  - RUN: every valid sample advances the decimation phase counter, which runs 0..DECIM-1 and wraps. The sample is "kept" when the phase is 0. The first kept sample is the first sample after warm-up.
- Write: a kept sample is written to `mem[wr_ptr]` when not full.
- Read: occurs when `Dout_valid && Dout_ready`. It advances `rd_ptr`. `Dout_ready` while empty is ignored.
- Simultaneous read and write:
  - When full: the write is accepted, because the read frees the slot in the same cycle. `Level` is unchanged.
  - When empty: only the write takes effect. There is no bypass.
- Full with no read: the kept sample is dropped, `Ovf` is set to 1, and `Drop_cnt` increments, saturating at 255.
- `Ovf_clr` coincident with a drop: the set wins. `Ovf`=1, `Drop_cnt`=1.
- Pointers are $clog2(DEPTH) bits wide and wrap naturally. `Level` is tracked separately.
- Data is stored unmodified: 14-bit two's complement, with no rounding or resizing.
- Reset asserted mid-operation immediately:
  - state goes to WARMUP and all counters and pointers go to 0;
  - `Dout_valid`=0, `Dout`=0, `Level`=0, `Ovf`=0, `Drop_cnt`=0;
  - FIFO contents are lost; the memory itself is not reset.

## Timing
- A kept sample present on `Din` at rising edge k appears on `Dout` with `Dout_valid`=1 after edge k, when the FIFO was empty. Latency is 1 cycle.
- `Dout`, `Dout_valid` and `Level` reflect register state only. There is no combinational path from `Dout_ready` or `Din` to any output.
- The head advances after the edge at which `Dout_ready` was sampled high with `Dout_valid`=1.
- `Ovf` and `Drop_cnt` update after the edge at which the drop occurs.
- With `Din_valid` held high and `Dout_ready` held high, the steady state is one output every DECIM cycles, and `Level` is ≤1.

## Configuration
- `HPF_DROP_CNT_EN` defined:
  - the 8-bit saturating `Drop_cnt` register is implemented as described.
- `HPF_DROP_CNT_EN` undefined:
  - `Drop_cnt` is tied to 0 and no counter logic is generated;
  - `Ovf` and all other behaviour are unchanged.

## Structure
- Shared package `hpf_pkg` holds:
  - `HPF_DATA_W` = 14;
  - `HPF_TAPS` = 13;
  - the state enum (`HPF_WARMUP`, `HPF_RUN`);
  - `HPF_DROP_CNT_W` = 8.
  - The filter and this block both take data width from the package.
- Sub-module `hpf_fifo`: storage, pointers, `Level`, full/empty, and the read/write arbitration.
- The top level contains the warm-up/decimation control and the overflow bookkeeping.

## Test plan
- Warm-up discard: reset, then stream `Din`=1..40 with `Din_valid`=1 and `Dout_ready`=1 → the first `Dout` is 14 and no value below 14 ever appears. `Dout_valid` rises 1 cycle after 14 is on `Din`.
- Decimation: DECIM=4, stream `Din`=1..40 → outputs 14, 18, 22, 26, …; gaps of 4 cycles between `Dout_valid` pulses.
- Fill and overflow: `Dout_ready`=0, stream 20 kept samples into DEPTH=16 → `Level`=16, `Ovf`=1, `Drop_cnt`=4 (0 without `HPF_DROP_CNT_EN`). Draining yields exactly the first 16 kept values in order.
- Full with simultaneous read/write: FIFO full, `Dout_ready`=1 for 1 cycle with a kept sample arriving → no drop, `Level` stays 16, `Ovf` stays 0, and the new value becomes the tail.
- Signed extremes: `Din`=-8192 and 8191 after warm-up → identical values emerge on `Dout`. `Dout`=0 whenever `Dout_valid`=0.
- Async reset mid-stream: assert `Rst` between edges with `Level`=7 and `Ovf`=1 → outputs clear immediately. After release, 13 further samples are discarded before the next output.

Source files
------------

// File: rtl/hpf_pkg.sv
// Shared definitions for the FIR high-pass filter and its output buffer.
package hpf_pkg;

  localparam int unsigned HPF_DATA_W     = 14;
  localparam int unsigned HPF_TAPS       = 13;
  localparam int unsigned HPF_DROP_CNT_W = 8;

  typedef enum logic [0:0] {
    HPF_WARMUP,
    HPF_RUN
  } hpf_state_e;

  function automatic logic [HPF_DROP_CNT_W-1:0] hpf_sat_inc(
    input logic [HPF_DROP_CNT_W-1:0] v
  );
    return (&v) ? v : v + HPF_DROP_CNT_W'(1);
  endfunction

endpackage

// File: rtl/hpf_fifo.sv
// Sample FIFO for the HPF output buffer: storage, pointers, occupancy and
// read/write arbitration. A write into a full FIFO succeeds only alongside a read.
module hpf_fifo
  import hpf_pkg::*;
#(
  parameter int unsigned Depth = 16
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic                         wr_req_i,
  input  logic signed [HPF_DATA_W-1:0] wr_data_i,
  input  logic                         rd_req_i,
  output logic signed [HPF_DATA_W-1:0] rd_data_o,
  output logic                         rd_valid_o,
  output logic [$clog2(Depth):0]       level_o,
  output logic                         drop_o
);

  localparam int unsigned PtrW = $clog2(Depth);
  localparam int unsigned LvlW = PtrW + 1;

  logic signed [HPF_DATA_W-1:0] mem_q [Depth];
  logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
  logic [LvlW-1:0] level_q, level_d;
  logic            full, empty, wr_en, rd_en;

  always_comb begin
    full     = (level_q == LvlW'(Depth));
    empty    = (level_q == '0);
    rd_en    = rd_req_i && !empty;
    // A read in the same cycle frees the slot, so full does not block the write.
    wr_en    = wr_req_i && (!full || rd_en);
    drop_o   = wr_req_i && full && !rd_en;
    wr_ptr_d = wr_en ? wr_ptr_q + PtrW'(1) : wr_ptr_q;
    rd_ptr_d = rd_en ? rd_ptr_q + PtrW'(1) : rd_ptr_q;
    level_d  = level_q;
    unique case ({wr_en, rd_en})
      2'b10:   level_d = level_q + LvlW'(1);
      2'b01:   level_d = level_q - LvlW'(1);
      default: level_d = level_q;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (wr_en) begin
      mem_q[wr_ptr_q] <= wr_data_i;
    end
  end

  assign rd_data_o  = empty ? '0 : mem_q[rd_ptr_q];
  assign rd_valid_o = !empty;
  assign level_o    = level_q;

endmodule

// File: rtl/hpf_out_buffer.sv
// HPF output buffer: warm-up discard, decimation, FIFO and overflow tracking.
// Define HPF_DROP_CNT_EN to implement the saturating Drop_cnt register.
module hpf_out_buffer
  import hpf_pkg::*;
#(
  parameter int unsigned WARMUP = HPF_TAPS,
  parameter int unsigned DECIM  = 1,
  parameter int unsigned DEPTH  = 16
) (
  input  logic                         Clk,
  input  logic                         Rst,
  input  logic signed [HPF_DATA_W-1:0] Din,
  input  logic                         Din_valid,
  output logic signed [HPF_DATA_W-1:0] Dout,
  output logic                         Dout_valid,
  input  logic                         Dout_ready,
  output logic [$clog2(DEPTH):0]       Level,
  output logic                         Ovf,
  input  logic                         Ovf_clr,
  output logic [HPF_DROP_CNT_W-1:0]    Drop_cnt
);

  localparam int unsigned WuW = (WARMUP > 1) ? $clog2(WARMUP) : 1;
  localparam int unsigned PhW = (DECIM > 1) ? $clog2(DECIM) : 1;
  localparam logic [WuW-1:0] WuLast = WuW'(WARMUP - 1);
  localparam logic [PhW-1:0] PhLast = PhW'(DECIM - 1);
  localparam hpf_state_e StReset = (WARMUP == 0) ? HPF_RUN : HPF_WARMUP;

  hpf_state_e     state_q, state_d;
  logic [WuW-1:0] wu_cnt_q, wu_cnt_d;
  logic [PhW-1:0] phase_q, phase_d;
  logic           ovf_q, ovf_d;
  logic           keep, drop;

  always_comb begin
    state_d  = state_q;
    wu_cnt_d = wu_cnt_q;
    phase_d  = phase_q;
    keep     = 1'b0;
    unique case (state_q)
      HPF_WARMUP: begin
        if (Din_valid) begin
          if (wu_cnt_q == WuLast) begin
            state_d  = HPF_RUN;
            wu_cnt_d = '0;
          end else begin
            wu_cnt_d = wu_cnt_q + WuW'(1);
          end
        end
      end
      HPF_RUN: begin
        if (Din_valid) begin
          keep    = (phase_q == '0);
          phase_d = (phase_q == PhLast) ? '0 : phase_q + PhW'(1);
        end
      end
      default: state_d = StReset;
    endcase
  end

  // A drop in the same cycle as a clear leaves the flag set.
  always_comb begin
    ovf_d = ovf_q;
    if (drop) begin
      ovf_d = 1'b1;
    end else if (Ovf_clr) begin
      ovf_d = 1'b0;
    end
  end

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      state_q  <= StReset;
      wu_cnt_q <= '0;
      phase_q  <= '0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      wu_cnt_q <= wu_cnt_d;
      phase_q  <= phase_d;
      ovf_q    <= ovf_d;
    end
  end

  assign Ovf = ovf_q;

`ifdef HPF_DROP_CNT_EN
  logic [HPF_DROP_CNT_W-1:0] drop_cnt_q, drop_cnt_d;

  always_comb begin
    drop_cnt_d = drop_cnt_q;
    if (drop) begin
      drop_cnt_d = Ovf_clr ? HPF_DROP_CNT_W'(1) : hpf_sat_inc(drop_cnt_q);
    end else if (Ovf_clr) begin
      drop_cnt_d = '0;
    end
  end

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      drop_cnt_q <= '0;
    end else begin
      drop_cnt_q <= drop_cnt_d;
    end
  end

  assign Drop_cnt = drop_cnt_q;
`else
  assign Drop_cnt = '0;
`endif

  hpf_fifo #(
    .Depth(DEPTH)
  ) u_fifo (
    .clk_i     (Clk),
    .rst_i     (Rst),
    .wr_req_i  (keep),
    .wr_data_i (Din),
    .rd_req_i  (Dout_ready),
    .rd_data_o (Dout),
    .rd_valid_o(Dout_valid),
    .level_o   (Level),
    .drop_o    (drop)
  );

endmodule

// File: tb/tb_hpf_out_buffer.sv
// Directed self-checking bench for hpf_out_buffer (DECIM=1 and DECIM=4 instances).
module tb_hpf_out_buffer;

  logic        clk = 1'b0;
  logic        rst;
  logic [13:0] din;
  logic        din_valid;
  logic        rdy, rdy4, ovf_clr;
  logic [13:0] dout, dout4;
  logic        dout_valid, dout_valid4;
  logic [4:0]  level, level4;
  logic        ovf, ovf4;
  logic [7:0]  drop_cnt, drop_cnt4;

  int checks = 0;
  int errors = 0;

`ifdef HPF_DROP_CNT_EN
  localparam int ExpDrop4 = 4;
  localparam int ExpDrop1 = 1;
`else
  localparam int ExpDrop4 = 0;
  localparam int ExpDrop1 = 0;
`endif

  always #5 clk = ~clk;

  hpf_out_buffer dut (
    .Clk       (clk),
    .Rst       (rst),
    .Din       (din),
    .Din_valid (din_valid),
    .Dout      (dout),
    .Dout_valid(dout_valid),
    .Dout_ready(rdy),
    .Level     (level),
    .Ovf       (ovf),
    .Ovf_clr   (ovf_clr),
    .Drop_cnt  (drop_cnt)
  );

  hpf_out_buffer #(
    .DECIM(4)
  ) dut4 (
    .Clk       (clk),
    .Rst       (rst),
    .Din       (din),
    .Din_valid (din_valid),
    .Dout      (dout4),
    .Dout_valid(dout_valid4),
    .Dout_ready(rdy4),
    .Level     (level4),
    .Ovf       (ovf4),
    .Ovf_clr   (1'b0),
    .Drop_cnt  (drop_cnt4)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b0; din = '0; din_valid = 1'b0; rdy = 1'b0; rdy4 = 1'b1; ovf_clr = 1'b0;
    #1 rst = 1'b1;
    step();
    check("rst_valid", dout_valid, 0);
    check("rst_dout", dout, 0);
    check("rst_level", level, 0);
    check("rst_ovf", ovf, 0);
    check("rst_drop", drop_cnt, 0);
    #2 rst = 1'b0;

    // Warm-up discard and decimation
    rdy = 1'b1;
    for (int v = 1; v <= 40; v++) begin
      din = 14'(v); din_valid = 1'b1;
      step();
      check("wu_valid", dout_valid, (v >= 14) ? 1 : 0);
      check("wu_dout", dout, (v >= 14) ? v : 0);
      check("dec_valid", dout_valid4, (v >= 14 && (v - 14) % 4 == 0) ? 1 : 0);
      check("dec_dout", dout4, (v >= 14 && (v - 14) % 4 == 0) ? v : 0);
    end
    din_valid = 1'b0;
    step();
    check("empty_level", level, 0);
    check("empty_dout", dout, 0);

    // Signed extremes
    din = 14'h2000; din_valid = 1'b1;
    step();
    check("neg_valid", dout_valid, 1);
    check("neg_dout", dout, 32'h2000);
    din = 14'h1fff;
    step();
    check("pos_dout", dout, 32'h1fff);
    din_valid = 1'b0;
    step();
    check("idle_valid", dout_valid, 0);
    check("idle_dout", dout, 0);

    // Fill and overflow
    rdy = 1'b0;
    for (int i = 0; i < 20; i++) begin
      din = 14'(100 + i); din_valid = 1'b1;
      step();
      if (i == 15) begin
        check("full_level", level, 16);
        check("full_ovf", ovf, 0);
      end
    end
    din_valid = 1'b0;
    check("ovf_level", level, 16);
    check("ovf_set", ovf, 1);
    check("ovf_drop", drop_cnt, ExpDrop4);
    rdy = 1'b1;
    for (int i = 0; i < 16; i++) begin
      check("drain_dout", dout, 100 + i);
      step();
    end
    check("drain_valid", dout_valid, 0);
    check("drain_level", level, 0);
    check("drain_ovf_sticky", ovf, 1);

    ovf_clr = 1'b1;
    step();
    ovf_clr = 1'b0;
    check("clr_ovf", ovf, 0);
    check("clr_drop", drop_cnt, 0);

    // Full with simultaneous read/write
    rdy = 1'b0;
    for (int i = 0; i < 16; i++) begin
      din = 14'(200 + i); din_valid = 1'b1;
      step();
    end
    check("rw_pre_level", level, 16);
    rdy = 1'b1; din = 14'(216);
    step();
    din_valid = 1'b0;
    check("rw_level", level, 16);
    check("rw_ovf", ovf, 0);
    check("rw_dout", dout, 201);
    for (int i = 1; i <= 16; i++) begin
      check("rw_drain", dout, 200 + i);
      step();
    end
    check("rw_empty", level, 0);
    check("rw_drop", drop_cnt, 0);

    // Clear coincident with a drop
    rdy = 1'b0;
    for (int i = 0; i < 16; i++) begin
      din = 14'(300 + i); din_valid = 1'b1;
      step();
    end
    din = 14'(316); ovf_clr = 1'b1;
    step();
    ovf_clr = 1'b0; din_valid = 1'b0;
    check("co_ovf", ovf, 1);
    check("co_drop", drop_cnt, ExpDrop1);
    check("co_level", level, 16);
    rdy = 1'b1;
    repeat (9) step();
    rdy = 1'b0;
    check("pre_rst_level", level, 7);
    check("pre_rst_dout", dout, 309);

    // Asynchronous reset mid-stream
    #3 rst = 1'b1;
    #1;
    check("arst_valid", dout_valid, 0);
    check("arst_dout", dout, 0);
    check("arst_level", level, 0);
    check("arst_ovf", ovf, 0);
    check("arst_drop", drop_cnt, 0);
    #2 rst = 1'b0;
    rdy = 1'b1;
    for (int v = 0; v < 15; v++) begin
      din = 14'(500 + v); din_valid = 1'b1;
      step();
      check("rewu_valid", dout_valid, (v >= 13) ? 1 : 0);
      check("rewu_dout", dout, (v >= 13) ? 500 + v : 0);
    end
    din_valid = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
